// File: rtl/mem_pkg.sv
// Shared definitions for the mem_access load/store stage: size codes, FSM states
// and the bus-timeout default.
package mem_pkg;

  localparam int DATA_W             = 32;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Natural alignment: halves need an even address, words a multiple of four.
  function automatic logic is_aligned(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~offset[0];
      default: return (offset == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction: picks the addressed byte/half out of a bus word and
// sign- or zero-extends it to a full word.
module load_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  size_e             size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] data
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: forwards ALU results, runs one bus load/store at a time.
// Optional bus-wait abort enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_ALUres,
  input  logic [DATA_W-1:0] i_op2,
  input  logic              i_memRead,
  input  logic              i_memWrite,
  input  logic [1:0]        i_size,
  input  logic              i_loadSigned,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic              o_misaligned,
  output logic              o_bus_error
);

  function automatic logic [3:0] store_be(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 4'b0001 << offset;
      SZ_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_wdata(input size_e size,
                                                    input logic [DATA_W-1:0] op2);
    case (size)
      SZ_BYTE: return {4{op2[7:0]}};
      SZ_HALF: return {2{op2[15:0]}};
      default: return op2;
    endcase
  endfunction

  state_e            state_q, state_nxt;
  size_e             size_in;
  logic              is_mem, aligned;
  logic              start, pass, misalign, done, abort, timeout_hit;

  logic              we_p1;
  logic [DATA_W-1:0] addr_p1;
  logic [3:0]        be_p1;
  logic [DATA_W-1:0] wdata_p1;
  size_e             size_p1;
  logic              sgn_p1;

  logic              vld_p2;
  logic [DATA_W-1:0] result_p2;
  logic              misaligned_p2;
  logic [DATA_W-1:0] load_data;

  assign size_in = size_e'(i_size);
  assign is_mem  = i_memRead | i_memWrite;
  assign aligned = is_aligned(size_in, i_ALUres[1:0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    start     = 1'b0;
    pass      = 1'b0;
    misalign  = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (!is_mem) begin
            pass = 1'b1;
          end else if (!aligned) begin
            misalign = 1'b1;
          end else begin
            start     = 1'b1;
            state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (i_mem_ack) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .rdata    (i_mem_rdata),
    .offset   (addr_p1[1:0]),
    .size     (size_p1),
    .sign_ext (sgn_p1),
    .data     (load_data)
  );

  // Stage p1: bus request captured on entry to BUSY, held until ack.
  // A simultaneous read+write is taken as a store.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      be_p1    <= '0;
      wdata_p1 <= '0;
      size_p1  <= SZ_BYTE;
      sgn_p1   <= 1'b0;
    end else if (start) begin
      we_p1    <= i_memWrite;
      addr_p1  <= i_ALUres;
      be_p1    <= store_be(size_in, i_ALUres[1:0]);
      wdata_p1 <= store_wdata(size_in, i_op2);
      size_p1  <= size_in;
      sgn_p1   <= i_loadSigned;
    end
  end

  // Stage p2: one-cycle result pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p2        <= 1'b0;
      result_p2     <= '0;
      misaligned_p2 <= 1'b0;
    end else begin
      vld_p2        <= pass | misalign | done | abort;
      misaligned_p2 <= misalign;
      if (pass || misalign) result_p2 <= i_ALUres;
      else if (done)        result_p2 <= we_p1 ? addr_p1 : load_data;
      else if (abort)       result_p2 <= '0;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] to_cnt_q;
  logic       bus_error_p2;

  // Counter is zero on the first BUSY cycle, so abort follows TIMEOUT_CYCLES req cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt_q     <= '0;
      bus_error_p2 <= 1'b0;
    end else begin
      bus_error_p2 <= abort;
      if (state_q == ST_BUSY) to_cnt_q <= to_cnt_q + 8'd1;
      else                    to_cnt_q <= '0;
    end
  end

  assign timeout_hit = (to_cnt_q == TO_LAST);
  assign o_bus_error = bus_error_p2;
`else
  assign timeout_hit = 1'b0;
  assign o_bus_error = 1'b0;
`endif

  assign o_stall      = (state_q == ST_BUSY);
  assign o_mem_req    = (state_q == ST_BUSY);
  assign o_mem_we     = (state_q == ST_BUSY) & we_p1;
  assign o_mem_addr   = {addr_p1[DATA_W-1:2], 2'b00};
  assign o_mem_be     = be_p1;
  assign o_mem_wdata  = wdata_p1;
  assign o_valid      = vld_p2;
  assign o_result     = result_p2;
  assign o_misaligned = misaligned_p2;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max bus-wait cycles before abort (used only with MEM_ACCESS_TIMEOUT_EN).
REQ-002 Clocking: one clock; reset asynchronous, active-high.
REQ-003 i_clk  input  1  rising-edge clock.
REQ-004 i_rst  input  1  async active-high reset.
REQ-005 i_valid  input  1  execute-stage result valid this cycle.
REQ-006 i_ALUres  input  32  ALU result; byte address for memory ops.
REQ-007 i_op2  input  32  store data from execute stage.
REQ-008 i_memRead, i_memWrite  input  1 each  load / store request.
REQ-009 i_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-010 i_loadSigned  input  1  1 = sign-extend loads, 0 = zero-extend.
REQ-011 o_stall  output  1  upstream holds inputs while high.
REQ-012 o_mem_req, o_mem_we  output  1 each  bus request / write strobe.
REQ-013 o_mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-014 o_mem_be  output  4  byte enables, little-endian.
REQ-015 o_mem_wdata  output  32  lane-replicated store data.
REQ-016 i_mem_ack  input  1  bus completion; i_mem_rdata input 32 valid when ack.
REQ-017 o_valid  output  1  one-cycle result pulse; o_result output 32.
REQ-018 o_misaligned, o_bus_error  output  1 each  qualify o_valid.

Function
REQ-019 FSM states SHALL be IDLE and BUSY; o_stall = (state==BUSY).
REQ-020 IDLE, i_valid, no mem op: register o_result=i_ALUres, o_valid=1 next cycle, stay IDLE.
REQ-021 IDLE, i_valid, aligned mem op: latch all inputs, go BUSY, o_mem_req=1 next cycle.
REQ-022 Alignment: half requires addr[0]=0, word requires addr[1:0]=0; a violating op SHALL issue no bus request and SHALL pulse o_valid with o_misaligned=1 and o_result=address the next cycle.
REQ-023 i_memRead and i_memWrite both high SHALL be treated as a store.
REQ-024 BUSY: o_mem_req, o_mem_we, o_mem_addr, o_mem_be and o_mem_wdata SHALL be held stable until i_mem_ack is sampled high.
REQ-025 Ack cycle: drop o_mem_req, return to IDLE, and pulse o_valid next cycle; minimum op latency is 2 cycles (ack in first req cycle).
REQ-026 Store lanes: byte be=1<<addr[1:0], wdata={4{op2[7:0]}}; half be=addr[1]?1100:0011, wdata={2{op2[15:0]}}; word be=1111, wdata=op2.
REQ-027 Load: select rdata byte/half by addr[1:0], extend to 32 bits per i_loadSigned; word passes through.
REQ-028 Store result: o_result=address.
REQ-029 i_mem_ack while IDLE SHALL be ignored; i_valid while BUSY SHALL be ignored.

Reset
REQ-030 Reset SHALL force state IDLE and zero all outputs, including o_mem_req, immediately (asynchronously).
REQ-031 Reset mid-BUSY SHALL abandon the op; a later stray ack SHALL be ignored.

Configuration
REQ-032 Macro MEM_ACCESS_TIMEOUT_EN defined: 8-bit counter runs in BUSY; after TIMEOUT_CYCLES cycles without ack, drop req, go IDLE, pulse o_valid with o_bus_error=1, o_result=0.
REQ-033 Macro undefined: no counter, BUSY waits indefinitely, o_bus_error tied 0.

Structure
REQ-034 Shared package mem_pkg SHALL hold size encodings, FSM state encoding, and the TIMEOUT_CYCLES default.
REQ-035 Combinational sub-module load_align SHALL perform lane select and extension; store lane logic stays inline.

Verification
REQ-036 Load word @0x100, ack after 3 cycles with rdata 0xDEADBEEF -> o_stall high 3 cycles, o_valid with o_result 0xDEADBEEF.
REQ-037 Signed byte load @0x103, rdata 0x80AABBCC -> o_result 0xFFFFFF80; unsigned -> 0x00000080.
REQ-038 Store half @0x202, op2 0x12345678 -> be 1100, wdata 0x56785678, addr 0x200.
REQ-039 Word load @0x101 -> no o_mem_req, o_valid with o_misaligned=1, o_result 0x101.
REQ-040 Reset asserted in BUSY, then ack pulsed -> o_mem_req 0 at once, no o_valid.
REQ-041 With MEM_ACCESS_TIMEOUT_EN and no ack -> after 255 cycles o_valid with o_bus_error=1, o_result 0.
